// File: rtl/proc_control.sv
// Control FSM for the simple processor: latches a 9-bit instruction from DIN and
// sequences bus-mux selects and load strobes over one to three execute cycles.
module proc_control #(
  parameter logic [3:0] SEL_G   = 4'd8,
  parameter logic [3:0] SEL_DIN = 4'd9
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  output logic [3:0]  sel,
  output logic [7:0]  Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        Done,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t      state;
  logic [8:0]  ir;
  logic [2:0]  op;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic        is_alu;
  logic        last;
  logic [7:0]  rx_onehot;

  assign op        = ir[8:6];
  assign rx        = ir[5:3];
  assign ry        = ir[2:0];
  assign is_alu    = (op[2:1] == 2'b01);
  assign last      = ((state == T1) && !is_alu) || (state == T3);
  assign rx_onehot = 8'd1 << rx;

  // The Done cycle also samples Run, so a held Run chains instructions with no idle gap.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      ir    <= 9'h000;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            ir    <= DIN[8:0];
            state <= T1;
          end
        end
        T1, T3: begin
          if (!last) begin
            state <= T2;
          end else if (Run) begin
            ir    <= DIN[8:0];
            state <= T1;
          end else begin
            state <= IDLE;
          end
        end
        T2:      state <= T3;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sel    = SEL_DIN;
    Rin    = 8'h00;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    Busy   = (state != IDLE);
    case (state)
      T1: begin
        Done = !is_alu;
        case (op)
          3'b000: begin
            sel = {1'b0, ry};
            Rin = rx_onehot;
          end
          3'b001: Rin = rx_onehot;
          3'b010, 3'b011: begin
            sel = {1'b0, rx};
            Ain = 1'b1;
          end
          default: ;
        endcase
      end
      T2: begin
        sel    = {1'b0, ry};
        Gin    = 1'b1;
        AddSub = op[0];
      end
      T3: begin
        sel  = SEL_G;
        Rin  = rx_onehot;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: an instruction-schedule model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_proc_control;

  logic        clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] DIN = 16'h0000;
  logic [3:0]  sel;
  logic [7:0]  Rin;
  logic        Ain, Gin, AddSub, Done, Busy;

  int tests = 0;
  int fails = 0;

  proc_control dut (
    .CLOCK_50(clk), .Resetn(Resetn), .Run(Run), .DIN(DIN),
    .sel(sel), .Rin(Rin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
    .Done(Done), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Model: an instruction in flight is its word plus how many execute cycles have elapsed.
  logic       m_busy = 1'b0;
  logic [8:0] m_ir = 9'h000;
  int         m_step = 0;

  function automatic int instr_len(logic [8:0] w);
    return (w[8:6] == 3'd2 || w[8:6] == 3'd3) ? 3 : 1;
  endfunction

  // {sel, Rin, Ain, Gin, AddSub, Done, Busy}
  function automatic logic [16:0] expected(logic busy, logic [8:0] w, int step);
    logic [3:0] s;
    logic [7:0] r;
    logic a, g, as, d;
    int x, y, op;
    s = 4'd9; r = 8'h00; a = 0; g = 0; as = 0; d = 0;
    op = int'(w[8:6]); x = int'(w[5:3]); y = int'(w[2:0]);
    if (busy) begin
      if (op == 0) begin
        s = 4'(y); r[x] = 1'b1; d = 1;
      end else if (op == 1) begin
        r[x] = 1'b1; d = 1;
      end else if (op == 2 || op == 3) begin
        if (step == 1) begin s = 4'(x); a = 1; end
        else if (step == 2) begin s = 4'(y); g = 1; as = (op == 3); end
        else begin s = 4'd8; r[x] = 1'b1; d = 1; end
      end else begin
        d = 1;
      end
    end
    return {s, r, a, g, as, d, busy};
  endfunction

  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      m_busy <= 1'b0;
      m_ir   <= 9'h000;
      m_step <= 0;
    end else if (!m_busy || m_step == instr_len(m_ir)) begin
      if (Run) begin
        m_busy <= 1'b1;
        m_ir   <= DIN[8:0];
        m_step <= 1;
      end else begin
        m_busy <= 1'b0;
      end
    end else begin
      m_step <= m_step + 1;
    end
  end

  always @(negedge clk) begin
    logic [16:0] exp_v, act_v, mask;
    exp_v = expected(m_busy, m_ir, m_step);
    act_v = {sel, Rin, Ain, Gin, AddSub, Done, Busy};
    mask  = exp_v[4] ? 17'h1FFFF : 17'h1FFFB;
    tests++;
    if ((act_v & mask) !== (exp_v & mask)) begin
      fails++;
      $display("FAIL model t=%0t got sel=%0d Rin=%h A=%b G=%b S=%b D=%b B=%b want sel=%0d Rin=%h A=%b G=%b S=%b D=%b B=%b",
               $time, act_v[16:13], act_v[12:5], act_v[4], act_v[3], act_v[2], act_v[1], act_v[0],
               exp_v[16:13], exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_sel"}, 8'(sel), 8'd9);
    chk({name, "_rin"}, Rin, 8'h00);
    chk({name, "_ctl"}, {4'd0, Ain, Gin, Done, Busy}, 8'h00);
  endtask

  task automatic launch(input logic [15:0] word);
    @(negedge clk);
    Run = 1'b1;
    DIN = word;
    @(negedge clk);
    Run = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    idle_chk("reset");
    $display("[TB] reset held 3 cycles");
    Resetn = 1'b1;

    launch(16'h0050);
    chk("mvi_sel", 8'(sel), 8'd9);
    chk("mvi_rin", Rin, 8'h04);
    chk("mvi_done", {7'd0, Done}, 8'd1);
    @(negedge clk);
    chk("mvi_busy_after", {7'd0, Busy}, 8'd0);
    $display("[TB] mvi R2 0x0050");

    launch(16'h001D);
    chk("mv_sel", 8'(sel), 8'd5);
    chk("mv_rin", Rin, 8'h08);
    chk("mv_done", {7'd0, Done}, 8'd1);
    $display("[TB] mv R3,R5 0x001D");

    launch(16'h0081);
    chk("add_t1", {4'(sel), Ain, Gin, Done, 1'b0}, {4'd0, 4'b1000});
    Run = 1'b1;
    @(negedge clk);
    chk("add_t2", {4'(sel), Ain, Gin, AddSub, Done}, {4'd1, 4'b0100});
    Run = 1'b0;
    @(negedge clk);
    chk("add_t3_sel", 8'(sel), 8'd8);
    chk("add_t3_rin", Rin, 8'h01);
    chk("add_t3_done", {7'd0, Done}, 8'd1);
    @(negedge clk);
    chk("add_idle", {7'd0, Busy}, 8'd0);
    $display("[TB] add R0,R1 0x0081 with Run toggled mid-instruction");

    launch(16'h00FE);
    chk("sub_t1", {4'(sel), Ain, Gin, Done, 1'b0}, {4'd7, 4'b1000});
    @(negedge clk);
    chk("sub_t2", {4'(sel), Ain, Gin, AddSub, Done}, {4'd6, 4'b0110});
    #2 Resetn = 1'b0;
    #1 idle_chk("abort");
    @(negedge clk);
    idle_chk("abort_hold");
    Resetn = 1'b1;
    @(negedge clk);
    chk("abort_no_done", {7'd0, Done}, 8'd0);
    launch(16'h0008);
    chk("mv10_sel", 8'(sel), 8'd0);
    chk("mv10_rin", Rin, 8'h02);
    chk("mv10_done", {7'd0, Done}, 8'd1);
    $display("[TB] sub R7,R6 aborted by reset, then mv R1,R0 0x0008");

    @(negedge clk);
    Run = 1'b1;
    DIN = 16'h0050;
    @(negedge clk);
    chk("b2b_mvi", {Rin[6:0], Done}, {7'h04, 1'b1});
    DIN = 16'h0100;
    @(negedge clk);
    chk("b2b_nop_done", {7'd0, Done}, 8'd1);
    chk("b2b_nop_rin", Rin, 8'h00);
    chk("b2b_nop_sel", 8'(sel), 8'd9);
    chk("b2b_nop_busy", {7'd0, Busy}, 8'd1);
    DIN = 16'h01C0;
    @(negedge clk);
    chk("b2b_nop7", {Rin[6:0], Done}, {7'h00, 1'b1});
    Run = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {Done, Busy, 6'd0}, 8'h00);
    $display("[TB] Run held across mvi, NOP 0x0100, NOP 0x01C0");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
